// File: rtl/data_word_access.sv
// data_word_access: load/store sequencer between the IL execution stage and
// the data word memory. Serves one LD/ST/INC/DEC request at a time, absorbs
// the memory's one-cycle registered-address read latency and gives INC/DEC
// an atomic read-modify-write.
// Optional feature macro: DATA_WORD_ACCESS_BOUNDS_CHECK_EN (rejects requests
// with REQ_ADDR >= DEPTH through a one-cycle ERR state).
module data_word_access #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [1:0]    REQ_OP,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [DW-1:0] REQ_DATA,
    output logic          RSP_VALID,
    output logic [DW-1:0] RSP_DATA,
    output logic          RSP_ERR,
    output logic [AW-1:0] MEM_A,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_DI,
    input  logic [DW-1:0] MEM_DQ
);

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;

    // A memory with no words is meaningless; catch it at elaboration.
    if (DEPTH < 1) begin : g_bad_depth
        $error("data_word_access: DEPTH must be at least 1");
    end

`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // One extra bit so DEPTH == 2**AW is representable.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
    logic addr_oob;
    assign addr_oob = ({1'b0, REQ_ADDR} >= DEPTH_LIM);
    logic rsp_err_q, rsp_err_d;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    assign REQ_READY = (state_q == S_IDLE);
    assign MEM_A     = addr_q;
    assign MEM_DI    = data_q;
    // Reset in the WR cycle must suppress the pending write.
    assign MEM_WE    = (state_q == S_WR) & ~RST;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
    assign RSP_ERR   = rsp_err_q;
`else
    assign RSP_ERR   = 1'b0;
`endif

    // Next-state, request latching and response generation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    op_d   = REQ_OP;
                    addr_d = REQ_ADDR;
                    data_d = REQ_DATA;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
                    if (addr_oob)
                        state_d = S_ERR;
                    else
`endif
                    if (REQ_OP == OP_ST)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            // Memory latches addr_q on the edge leaving RD.
            S_RD: state_d = S_CAP;
            // MEM_DQ now holds the word at addr_q.
            S_CAP: begin
                if (op_q == OP_LD) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MEM_DQ;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = S_IDLE;
                end else begin
                    // Step value lives in data_q; result wraps mod 2**DW.
                    data_d  = (op_q == OP_INC) ? (MEM_DQ + data_q) : (MEM_DQ - data_q);
                    state_d = S_WR;
                end
            end
            // Write happens on the edge leaving WR; respond with written value.
            S_WR: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_q;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
                rsp_err_d   = 1'b0;
`endif
                state_d     = S_IDLE;
            end
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b1;
                state_d     = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_word_access.sv
// Randomized scoreboard bench for data_word_access with a registered-address
// memory model and a word-level reference model of the memory contents.
module tb_data_word_access;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int MWORDS = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic [1:0]    REQ_OP = 2'b00;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_DATA = '0;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_DATA;
    logic          RSP_ERR;
    logic [AW-1:0] MEM_A;
    logic          MEM_WE;
    logic [DW-1:0] MEM_DI;
    logic [DW-1:0] MEM_DQ;

    data_word_access #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .MEM_A(MEM_A), .MEM_WE(MEM_WE), .MEM_DI(MEM_DI), .MEM_DQ(MEM_DQ)
    );

    always #5 CLK = ~CLK;

    // Memory: synchronous write, registered read address.
    logic [DW-1:0] mem [MWORDS];
    logic [AW-1:0] a_reg = '0;
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_A[5:0]] <= MEM_DI;
        a_reg <= MEM_A;
    end
    assign MEM_DQ = mem[a_reg[5:0]];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int we_cycles = 0;
    int exp_writes = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ref_mem [MWORDS];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pops one expectation.
    always @(negedge CLK) begin
        if (!RST && MEM_WE) begin
            we_cycles++;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
            chk("we_in_range", {31'd0, (MEM_A < AW'(DEPTH))}, 32'd1);
`endif
        end
        if (RSP_VALID) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", RSP_DATA, e.data);
                chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, e.err});
                chk("rsp_latency", DW'(cyc), DW'(e.cyc));
            end
        end
    end

    // Reference: word semantics of each op, applied at acceptance.
    function automatic exp_t model(input logic [1:0] op, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] d, input int n);
        exp_t e;
        int lat;
        e.err = 1'b0;
        e.data = '0;
`ifdef DATA_WORD_ACCESS_BOUNDS_CHECK_EN
        if (int'(addr) >= DEPTH) begin
            e.err = 1'b1;
            e.cyc = n + 1;
            return e;
        end
`endif
        case (op)
            2'b00: begin e.data = ref_mem[addr]; lat = 2; end
            2'b01: begin ref_mem[addr] = d; e.data = d; lat = 1; exp_writes++; end
            2'b10: begin ref_mem[addr] = ref_mem[addr] + d; e.data = ref_mem[addr]; lat = 3; exp_writes++; end
            default: begin ref_mem[addr] = ref_mem[addr] - d; e.data = ref_mem[addr]; lat = 3; exp_writes++; end
        endcase
        e.cyc = n + lat;
        return e;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        bit ok;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP = op;
        REQ_ADDR = addr;
        REQ_DATA = d;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (REQ_READY) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        if (!ok) begin
            chk("ready_timeout", 32'd0, 32'd1);
            REQ_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        sb.push_back(model(op, addr, d, cyc));
    endtask

    task automatic drain();
        for (int t = 0; t < 20; t++) begin
            if (sb.size() == 0 && REQ_READY) return;
            @(negedge CLK);
        end
        chk("drain_timeout", DW'(sb.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < MWORDS; i++) mem[i] = $urandom;
        mem[0] = 32'd500;
        mem[3] = 32'd5;
        mem[8] = 32'd0;
        mem[2] = 32'd1;
        for (int i = 0; i < MWORDS; i++) ref_mem[i] = mem[i];

        // Reset held two cycles with a request pending.
        RST = 1'b1;
        REQ_VALID = 1'b1;
        REQ_OP = 2'b01;
        REQ_ADDR = 16'd5;
        REQ_DATA = 32'h1234;
        repeat (2) begin
            @(negedge CLK);
            chk("rst_ready", {31'd0, REQ_READY}, 32'd1);
            chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
            chk("rst_rsp_data", RSP_DATA, 32'd0);
            chk("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
            chk("rst_rsp_err", {31'd0, RSP_ERR}, 32'd0);
        end
        RST = 1'b0;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("post_rst_idle", {31'd0, REQ_READY}, 32'd1);

        // Directed cases.
        do_req(2'b00, 16'd0, 32'd0);
        do_req(2'b01, 16'd7, 32'hDEADBEEF);
        do_req(2'b00, 16'd7, 32'd0);
        do_req(2'b10, 16'd3, 32'd2);
        do_req(2'b00, 16'd3, 32'd0);
        do_req(2'b11, 16'd8, 32'd1);
        drain();

        // Reset during the WR cycle of a store: write and response dropped.
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP = 2'b01;
        REQ_ADDR = 16'd2;
        REQ_DATA = 32'd9;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_wr_mem_we", {31'd0, MEM_WE}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_wr_no_rsp", {31'd0, RSP_VALID}, 32'd0);
        chk("rst_wr_idle", {31'd0, REQ_READY}, 32'd1);
        do_req(2'b00, 16'd2, 32'd0);

        // Out-of-range store (error under the bounds check, plain store otherwise).
        do_req(2'b01, 16'd40, 32'h55AA55AA);
        do_req(2'b00, 16'd40, 32'd0);
        do_req(2'b10, 16'd33, 32'd1);
        drain();

        // Random mix including wrap-around steps and out-of-range addresses.
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [DW-1:0] d;
            op = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? $urandom : DW'($urandom_range(0, 7));
            do_req(op, AW'($urandom_range(0, 47)), d);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
        end
        drain();
        repeat (3) @(negedge CLK);
        chk("write_count", DW'(we_cycles), DW'(exp_writes));
        chk("sb_empty", DW'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
